// File: rtl/ram_sp_sr_sw_ctrl_if.sv
// Request/response handshake bundle between a system-side master and ram_sp_sr_sw_ctrl.
// The master issues single read/write requests and consumes read responses.
interface ram_sp_sr_sw_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram_sp_sr_sw_ctrl.sv
// Single-port synchronous RAM initiator: sequences cs/we/oe and the shared data bus per request.
// Optional RAM_CTRL_TURNAROUND_EN adds a dead TURN cycle after every read response handshake.
module ram_sp_sr_sw_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    ram_sp_sr_sw_ctrl_if.slave    bus,
    output logic [ADDR_WIDTH-1:0] ram_address,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdAddr,
        StRdData,
        StRsp,
        StTurn
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    assign bus.req_ready = (state_q == StIdle) && !reset;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // Drive enable is ram_we itself, so direction and write strobe always flip on one edge.
    assign ram_data = ram_we ? wdata_q : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ram_address <= '0;
            wdata_q     <= '0;
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_oe      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        ram_address <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        ram_cs      <= 1'b1;
                        if (bus.req_we) begin
                            ram_we  <= 1'b1;
                            state_q <= StWr;
                        end else begin
                            ram_oe  <= 1'b1;
                            state_q <= StRdAddr;
                        end
                    end
                end
                StWr: begin
                    ram_cs  <= 1'b0;
                    ram_we  <= 1'b0;
                    state_q <= StIdle;
                end
                StRdAddr: begin
                    state_q <= StRdData;
                end
                StRdData: begin
                    rsp_rdata_q <= ram_data;
                    rsp_valid_q <= 1'b1;
                    ram_cs      <= 1'b0;
                    ram_oe      <= 1'b0;
                    state_q     <= StRsp;
                end
                StRsp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
`ifdef RAM_CTRL_TURNAROUND_EN
                        state_q     <= StTurn;
`else
                        state_q     <= StIdle;
`endif
                    end
                end
                StTurn: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    a_no_we_with_oe: assert property (@(posedge clk) disable iff (reset) !(ram_we && ram_oe));
    a_rsp_stable: assert property (@(posedge clk) disable iff (reset)
        (rsp_valid_q && !bus.rsp_ready) |=> (rsp_valid_q && $stable(rsp_rdata_q)));

endmodule

// File: tb/tb_ram_sp_sr_sw_ctrl.sv
// Self-checking bench for ram_sp_sr_sw_ctrl: timestamped transaction model checked every cycle,
// a behavioural single-port RAM on the pin side, directed cases plus randomized traffic.
module tb_ram_sp_sr_sw_ctrl;
    localparam int DW = 8;
    localparam int AW = 8;
`ifdef RAM_CTRL_TURNAROUND_EN
    localparam bit TURN = 1'b1;
`else
    localparam bit TURN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_sp_sr_sw_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    wire  [DW-1:0] ram_data;
    logic [AW-1:0] ram_address;
    logic          ram_cs;
    logic          ram_we;
    logic          ram_oe;

    ram_sp_sr_sw_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_cs      (ram_cs),
        .ram_we      (ram_we),
        .ram_oe      (ram_oe)
    );

    // Pin-side RAM: registered output, drives the bus while selected and output-enabled.
    logic [DW-1:0] ram_mem [256];
    logic [DW-1:0] ram_dout;
    always @(posedge clk) begin
        if (ram_cs && ram_we) ram_mem[ram_address] <= ram_data;
        else if (ram_cs && ram_oe) ram_dout <= ram_mem[ram_address];
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_dout : {DW{1'bz}};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t: timed out waiting for DUT", name, $time);
    endtask

    // Reference model: memory contents plus the timestamps of the one outstanding transaction.
    logic [DW-1:0] mem_model [256];
    bit            mem_known [256];
    bit            op_act = 1'b0;
    bit            op_we;
    bit            op_known;
    logic [AW-1:0] op_addr;
    logic [DW-1:0] op_wdata;
    logic [DW-1:0] op_exp;
    int            op_t;
    int            op_h;
    int            e = 0;
    bit            rst_at_e = 1'b1;

    always @(negedge clk) begin
        bit b, xcs, xwe, xoe, xrv, xrdy;
        e++;
        b = 1'b0;
        if (op_act) b = op_we ? (e == op_t) : (op_h < 0 || (TURN && e == op_h));
        if (op_act && !b) op_act = 1'b0;
        xcs  = op_act && (op_we || e <= op_t + 1);
        xwe  = op_act && op_we;
        xoe  = op_act && !op_we && e <= op_t + 1;
        xrv  = op_act && !op_we && e >= op_t + 2 && op_h < 0;
        xrdy = !reset && !b;
        check("pins{cs,we,oe,rsp_valid,req_ready}",
              {27'd0, ram_cs, ram_we, ram_oe, bus.rsp_valid, bus.req_ready},
              {27'd0, xcs, xwe, xoe, xrv, xrdy});
        if (rst_at_e) begin
            check("reset_address", 32'(ram_address), 32'd0);
            check("reset_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        end
        if (xcs) check("ram_address", 32'(ram_address), 32'(op_addr));
        if (xwe) check("ram_data_write", 32'(ram_data), 32'(op_wdata));
        if (xoe && e == op_t + 1 && op_known) check("ram_data_read", 32'(ram_data), 32'(op_exp));
        if (xrv && op_known) check("rsp_rdata", 32'(bus.rsp_rdata), 32'(op_exp));

        // Decide what the coming edge does.
        if (reset) begin
            op_act   = 1'b0;
            rst_at_e = 1'b1;
        end else begin
            rst_at_e = 1'b0;
            if (xrdy && bus.req_valid) begin
                op_act   = 1'b1;
                op_we    = bus.req_we;
                op_addr  = bus.req_addr;
                op_wdata = bus.req_wdata;
                op_t     = e + 1;
                op_h     = -1;
                if (bus.req_we) begin
                    mem_model[bus.req_addr] = bus.req_wdata;
                    mem_known[bus.req_addr] = 1'b1;
                end else begin
                    op_exp   = mem_model[bus.req_addr];
                    op_known = mem_known[bus.req_addr];
                end
            end else if (xrv && bus.rsp_ready) begin
                op_h = e + 1;
            end
        end
    end

    task automatic send(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int waits);
        bit done = 1'b0;
        waits = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
                break;
            end
            waits++;
        end
        bus.req_valid = 1'b0;
        if (!done) timeout("req_accept");
    endtask

    // hold < 0: random rsp_ready; else rsp_ready low for 'hold' cycles of rsp_valid.
    task automatic get_rsp(input int hold, output logic [DW-1:0] d);
        bit done = 1'b0;
        int nv = 0;
        d = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                if (bus.rsp_ready) begin
                    d = bus.rsp_rdata;
                    @(posedge clk);
                    #1;
                    done = 1'b1;
                    break;
                end
                nv++;
            end
            @(posedge clk);
            #1;
            bus.rsp_ready = (hold < 0) ? ($urandom_range(0, 2) == 0) : (nv >= hold);
        end
        bus.rsp_ready = 1'b0;
        if (!done) timeout("rsp_handshake");
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int w;
        send(1'b1, a, d, w);
    endtask

    task automatic rd_lit(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        int w;
        logic [DW-1:0] d;
        send(1'b0, a, '0, w);
        get_rsp(0, d);
        check(name, 32'(d), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [DW-1:0] d;
        for (int i = 0; i < 256; i++) mem_known[i] = 1'b0;
        ram_dout      = '0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 8'h12;
        bus.req_wdata = 8'hA5;
        bus.rsp_ready = 1'b0;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset         = 1'b0;

        wr(8'h12, 8'hA5);
        rd_lit("read_0x12", 8'h12, 8'hA5);
        wr(8'h00, 8'h01);
        wr(8'hFF, 8'hFE);
        rd_lit("read_0x00", 8'h00, 8'h01);
        rd_lit("read_0xFF", 8'hFF, 8'hFE);

        // Backpressure with a write request waiting behind the held response.
        wr(8'h40, 8'h77);
        send(1'b0, 8'h40, '0, w);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 8'h41;
        bus.req_wdata = 8'h99;
        get_rsp(5, d);
        check("backpressure_rdata", 32'(d), 32'h77);
        send(1'b1, 8'h41, 8'h99, w);
        rd_lit("read_0x41", 8'h41, 8'h99);

        // Read immediately followed by write: one extra wait when the turnaround cycle exists.
        send(1'b0, 8'h12, '0, w);
        get_rsp(0, d);
        send(1'b1, 8'h13, 8'h3C, w);
        check("read_to_write_waits", 32'(w), TURN ? 32'd1 : 32'd0);
        rd_lit("read_0x13", 8'h13, 8'h3C);

        // Reset while the read is in its data cycle.
        send(1'b0, 8'h12, '0, w);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_cs", 32'(ram_cs), 32'd0);
        wr(8'h33, 8'h5A);
        rd_lit("read_0x33", 8'h33, 8'h5A);

        for (int n = 0; n < 300; n++) begin
            logic [AW-1:0] a;
            a = {($urandom_range(0, 1) == 1) ? 4'hF : 4'h0, 4'($urandom_range(0, 15))};
            bus.rsp_ready = ($urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            if ($urandom_range(0, 1) == 1) begin
                send(1'b1, a, 8'($urandom), w);
            end else begin
                send(1'b0, a, '0, w);
                if ($urandom_range(0, 39) == 0) begin
                    reset = 1'b1;
                    @(posedge clk);
                    #1;
                    reset = 1'b0;
                end else begin
                    get_rsp(-1, d);
                end
            end
        end
        bus.rsp_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
